// File: rtl/counter_pkg.sv
// Shared types for the mode_counter timebase/sequencer.
package counter_pkg;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'd0,
    DOWN_WRAP = 2'd1,
    PING_PONG = 2'd2,
    UP_SAT    = 2'd3
  } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles down to one step every CLOCKS_PER_INCREMENT cycles.
module tick_prescaler #(
  parameter int CLOCKS_PER_INCREMENT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic step
);

  localparam int PW = (CLOCKS_PER_INCREMENT > 1) ? $clog2(CLOCKS_PER_INCREMENT) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLOCKS_PER_INCREMENT - 1);

  logic [PW-1:0] presc;

  assign step = en && (presc == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
    end else if (clear || step) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + PW'(1);
    end else begin
      presc <= presc;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Bounded MIN..MAX counter with runtime mode, enable, clamped load and terminal-count pulse.
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH                = 8,
  parameter int CLOCKS_PER_INCREMENT = 1,
  parameter int MIN_VALUE            = 0,
  parameter int MAX_VALUE            = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  mode_e            mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc
);

  if (MIN_VALUE > MAX_VALUE) begin : g_bad_bounds
    $error("mode_counter: MIN_VALUE must not exceed MAX_VALUE");
  end
  if (longint'(MAX_VALUE) >= (longint'(1) << WIDTH)) begin : g_bad_width
    $error("mode_counter: MAX_VALUE does not fit in WIDTH bits");
  end
  if (CLOCKS_PER_INCREMENT < 1) begin : g_bad_cpi
    $error("mode_counter: CLOCKS_PER_INCREMENT must be at least 1");
  end

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic             step;
  logic             fresh;
  logic             pp_up;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             tc_nxt;
  logic             fresh_nxt;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v < MIN_V) begin
      return MIN_V;
    end else if (v > MAX_V) begin
      return MAX_V;
    end else begin
      return v;
    end
  endfunction

  // Direction a mode implies at value v; ping-pong turns around at either bound.
  function automatic logic mode_dir(input mode_e m, input logic [WIDTH-1:0] v, input logic d);
    case (m)
      UP_WRAP, UP_SAT: return 1'b1;
      DOWN_WRAP:       return 1'b0;
      PING_PONG: begin
        if (v == MAX_V) begin
          return 1'b0;
        end else if (v == MIN_V) begin
          return 1'b1;
        end else begin
          return d;
        end
      end
      default:         return d;
    endcase
  endfunction

  tick_prescaler #(
    .CLOCKS_PER_INCREMENT(CLOCKS_PER_INCREMENT)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(load),
    .step (step)
  );

  assign pp_up = mode_dir(PING_PONG, count, dir);

  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    tc_nxt    = 1'b0;
    fresh_nxt = fresh;
    if (load) begin
      count_nxt = clamp(load_value);
      dir_nxt   = mode_dir(mode, count_nxt, dir);
      fresh_nxt = 1'b0;
    end else if (step) begin
      fresh_nxt = 1'b0;
      case (mode)
        UP_WRAP: begin
          count_nxt = (count == MAX_V) ? MIN_V : count + WIDTH'(1);
          tc_nxt    = (count == MAX_V);
          dir_nxt   = 1'b1;
        end
        DOWN_WRAP: begin
          count_nxt = (count == MIN_V) ? MAX_V : count - WIDTH'(1);
          tc_nxt    = (count == MIN_V);
          dir_nxt   = 1'b0;
        end
        PING_PONG: begin
          // Bounds are re-checked so a single-value range never over/underflows.
          if (pp_up && (count < MAX_V)) begin
            count_nxt = count + WIDTH'(1);
          end else if (!pp_up && (count > MIN_V)) begin
            count_nxt = count - WIDTH'(1);
          end else begin
            count_nxt = count;
          end
          tc_nxt  = (count_nxt == MAX_V) || (count_nxt == MIN_V);
          dir_nxt = mode_dir(PING_PONG, count_nxt, pp_up);
        end
        UP_SAT: begin
          if (count < MAX_V) begin
            count_nxt = count + WIDTH'(1);
            tc_nxt    = (count_nxt == MAX_V);
          end else begin
            count_nxt = MAX_V;
            tc_nxt    = fresh;
          end
          dir_nxt = 1'b1;
        end
        default: begin
          count_nxt = count;
        end
      endcase
    end else begin
      dir_nxt = mode_dir(mode, count, dir);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= MIN_V;
      dir   <= 1'b1;
      tc    <= 1'b0;
      fresh <= 1'b1;
    end else begin
      count <= count_nxt;
      dir   <= dir_nxt;
      tc    <= tc_nxt;
      fresh <= fresh_nxt;
    end
  end

endmodule
